esfa_array_controller: RTL and testbench

Command sequencer for the ESFA cell array: accepts host commands over a valid/ready interface and broadcasts the selector and operands to all cells. It captures the per-cell registered responses (bool, result value, context) and reduces them to a single response: hit flag, lowest hit index, count, value and context. It also implements the composite allocate-and-insert operation, a free-cell scan followed by an update. It sits between the host/software-facing bus and the replicated MemoryCell array, where each cell's handle is tied to its cell index.

---
 rtl/esfa_pkg.sv | 25 ++
 rtl/esfa_hit_reduce.sv | 36 +++
 rtl/esfa_array_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_esfa_array_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/esfa_pkg.sv
// Shared opcode, selector and state definitions for the ESFA array controller.
package esfa_pkg;
    localparam logic [3:0] OP_UPDATE       = 4'd0;
    localparam logic [3:0] OP_LOOKUP       = 4'd1;
    localparam logic [3:0] OP_ENCODE       = 4'd2;
    localparam logic [3:0] OP_CONG_UP      = 4'd3;
    localparam logic [3:0] OP_CONG_DOWN    = 4'd4;
    localparam logic [3:0] OP_MARK_AVAIL   = 4'd5;
    localparam logic [3:0] OP_ENRANK       = 4'd6;
    localparam logic [3:0] OP_ENRANGE      = 4'd7;
    localparam logic [3:0] OP_ALLOC_INSERT = 4'd8;

    localparam logic [7:0] SEL_IDLE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP,
        ST_ALLOC_ISSUE2,
        ST_ALLOC_WAIT2,
        ST_ALLOC_CAP2
    } state_e;
endpackage

// File: rtl/esfa_hit_reduce.sv
// Combinational reduction of per-cell responses: lowest-index hit, popcount,
// and the result/context of the winning cell.
module esfa_hit_reduce #(
    parameter int NUM_CELLS = 8,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = $clog2(NUM_CELLS + 1)
) (
    input  logic [NUM_CELLS-1:0]        cell_bool,
    input  logic [DATA_W*NUM_CELLS-1:0] cell_result,
    input  logic [DATA_W*NUM_CELLS-1:0] cell_context,
    output logic                        hit,
    output logic [7:0]                  hit_cell,
    output logic [CNT_W-1:0]            hit_count,
    output logic [DATA_W-1:0]           hit_value,
    output logic [DATA_W-1:0]           hit_context
);
    always_comb begin
        hit         = 1'b0;
        hit_cell    = '0;
        hit_count   = '0;
        hit_value   = '0;
        hit_context = '0;
        // descending scan: the lowest set index is the last one to write
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (cell_bool[i]) begin
                hit         = 1'b1;
                hit_cell    = 8'(i);
                hit_value   = cell_result[DATA_W*i +: DATA_W];
                hit_context = cell_context[DATA_W*i +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            hit_count = hit_count + CNT_W'(cell_bool[i]);
        end
    end
endmodule

// File: rtl/esfa_array_controller.sv
// Command sequencer for the ESFA cell array: issues one broadcast selector per
// host command, reduces the cell responses, and runs allocate-and-insert.
//
// state           | meaning
// ST_IDLE         | cmd_ready high, waiting for a host command
// ST_ISSUE        | selector and operands on the broadcast bus for one edge
// ST_WAIT         | cells present registered outputs; reduction captured on exit
// ST_CAPTURE      | reduction held; decides response or second alloc cycle
// ST_ALLOC_ISSUE2 | update selector with metadata = free cell index
// ST_ALLOC_WAIT2  | update outputs valid; captured on exit
// ST_ALLOC_CAP2   | update result held, response follows
// ST_RESP         | rsp_valid high until rsp_ready
module esfa_array_controller
    import esfa_pkg::*;
#(
    parameter  int NUM_CELLS = 8,
    parameter  int DATA_W    = 8,
    localparam int CNT_W     = $clog2(NUM_CELLS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd_op,
    input  logic [DATA_W-1:0]           cmd_index,
    input  logic [DATA_W-1:0]           cmd_value,
    input  logic [DATA_W-1:0]           cmd_metadata,
    input  logic                        cmd_is_meta,
    output logic [7:0]                  cell_selector,
    output logic [DATA_W-1:0]           cell_index,
    output logic [DATA_W-1:0]           cell_value,
    output logic [DATA_W-1:0]           cell_metadata,
    output logic                        cell_is_meta,
    input  logic [NUM_CELLS-1:0]        cell_bool,
    input  logic [DATA_W*NUM_CELLS-1:0] cell_result,
    input  logic [DATA_W*NUM_CELLS-1:0] cell_context,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_hit,
    output logic [7:0]                  rsp_cell,
    output logic [CNT_W-1:0]            rsp_count,
    output logic [DATA_W-1:0]           rsp_value,
    output logic [DATA_W-1:0]           rsp_context,
    output logic                        rsp_err
);
    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [7:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   cell_index_q, cell_index_d, cell_value_q, cell_value_d;
    logic [DATA_W-1:0]   cell_metadata_q, cell_metadata_d;
    logic                cell_is_meta_q, cell_is_meta_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_err_q, rsp_err_d;
    logic [7:0]          rsp_cell_q, rsp_cell_d;
    logic [CNT_W-1:0]    rsp_count_q, rsp_count_d;
    logic [DATA_W-1:0]   rsp_value_q, rsp_value_d, rsp_context_q, rsp_context_d;

    logic                red_hit;
    logic [7:0]          red_cell;
    logic [CNT_W-1:0]    red_count;
    logic [DATA_W-1:0]   red_value, red_context, f_value, f_context;

    esfa_hit_reduce #(.NUM_CELLS(NUM_CELLS), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_reduce (
        .cell_bool   (cell_bool),
        .cell_result (cell_result),
        .cell_context(cell_context),
        .hit         (red_hit),
        .hit_cell    (red_cell),
        .hit_count   (red_count),
        .hit_value   (red_value),
        .hit_context (red_context)
    );

    // after the update cycle the response reports the allocated cell, not the lowest hit
    always_comb begin
        f_value   = '0;
        f_context = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (rsp_cell_q == 8'(i)) begin
                f_value   = cell_result[DATA_W*i +: DATA_W];
                f_context = cell_context[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cmd_ready_d     = 1'b0;
        sel_d           = SEL_IDLE;
        cell_index_d    = cell_index_q;
        cell_value_d    = cell_value_q;
        cell_metadata_d = cell_metadata_q;
        cell_is_meta_d  = cell_is_meta_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_hit_d       = rsp_hit_q;
        rsp_cell_d      = rsp_cell_q;
        rsp_count_d     = rsp_count_q;
        rsp_value_d     = rsp_value_q;
        rsp_context_d   = rsp_context_q;
        rsp_err_d       = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    cmd_ready_d     = 1'b0;
                    op_d            = cmd_op;
                    cell_index_d    = cmd_index;
                    cell_value_d    = cmd_value;
                    cell_metadata_d = cmd_metadata;
                    cell_is_meta_d  = cmd_is_meta;
                    rsp_hit_d       = 1'b0;
                    rsp_cell_d      = '0;
                    rsp_count_d     = '0;
                    rsp_value_d     = '0;
                    rsp_context_d   = '0;
                    rsp_err_d       = 1'b0;
                    if (cmd_op > OP_ALLOC_INSERT) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        sel_d   = (cmd_op == OP_ALLOC_INSERT) ? 8'(OP_MARK_AVAIL) : 8'(cmd_op[2:0]);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                rsp_hit_d     = red_hit;
                rsp_cell_d    = red_cell;
                rsp_count_d   = red_count;
                rsp_value_d   = red_value;
                rsp_context_d = red_context;
                state_d       = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (op_q == OP_ALLOC_INSERT && rsp_hit_q) begin
                    sel_d           = 8'(OP_UPDATE);
                    cell_metadata_d = rsp_cell_q;
                    cell_is_meta_d  = 1'b1;
                    state_d         = ST_ALLOC_ISSUE2;
                end else begin
                    rsp_err_d   = (op_q == OP_ALLOC_INSERT);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_ALLOC_ISSUE2: state_d = ST_ALLOC_WAIT2;
            ST_ALLOC_WAIT2: begin
                rsp_hit_d     = red_hit;
                rsp_count_d   = red_count;
                rsp_value_d   = f_value;
                rsp_context_d = f_context;
                state_d       = ST_ALLOC_CAP2;
            end
            ST_ALLOC_CAP2: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            op_q            <= '0;
            cmd_ready_q     <= 1'b1;
            sel_q           <= SEL_IDLE;
            cell_index_q    <= '0;
            cell_value_q    <= '0;
            cell_metadata_q <= '0;
            cell_is_meta_q  <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_cell_q      <= '0;
            rsp_count_q     <= '0;
            rsp_value_q     <= '0;
            rsp_context_q   <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            cmd_ready_q     <= cmd_ready_d;
            sel_q           <= sel_d;
            cell_index_q    <= cell_index_d;
            cell_value_q    <= cell_value_d;
            cell_metadata_q <= cell_metadata_d;
            cell_is_meta_q  <= cell_is_meta_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_hit_q       <= rsp_hit_d;
            rsp_cell_q      <= rsp_cell_d;
            rsp_count_q     <= rsp_count_d;
            rsp_value_q     <= rsp_value_d;
            rsp_context_q   <= rsp_context_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign cell_selector = sel_q;
    assign cell_index    = cell_index_q;
    assign cell_value    = cell_value_q;
    assign cell_metadata = cell_metadata_q;
    assign cell_is_meta  = cell_is_meta_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_hit       = rsp_hit_q;
    assign rsp_cell      = rsp_cell_q;
    assign rsp_count     = rsp_count_q;
    assign rsp_value     = rsp_value_q;
    assign rsp_context   = rsp_context_q;
    assign rsp_err       = rsp_err_q;
endmodule

// File: tb/tb_esfa_array_controller.sv
// Randomized bench for esfa_array_controller with a behavioural cell array and
// a reference model of the reduced response.
module tb_esfa_array_controller;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic [7:0]   cmd_index = '0, cmd_value = '0, cmd_metadata = '0;
    logic         cmd_is_meta = 1'b0;
    logic [7:0]   cell_selector, cell_index, cell_value, cell_metadata;
    logic         cell_is_meta;
    logic [N-1:0] cell_bool = '0;
    logic [8*N-1:0] cell_result = '0, cell_context = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_hit, rsp_err;
    logic [7:0]   rsp_cell, rsp_value, rsp_context;
    logic [3:0]   rsp_count;

    esfa_array_controller #(.NUM_CELLS(N), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .cmd_value(cmd_value), .cmd_metadata(cmd_metadata),
        .cmd_is_meta(cmd_is_meta),
        .cell_selector(cell_selector), .cell_index(cell_index), .cell_value(cell_value),
        .cell_metadata(cell_metadata), .cell_is_meta(cell_is_meta),
        .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_cell(rsp_cell),
        .rsp_count(rsp_count), .rsp_value(rsp_value), .rsp_context(rsp_context),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // planned cell responses: [0] for the first issue (scan/single op), [1] for the alloc update
    logic [N-1:0] plan_bool [2];
    logic [7:0]   plan_res  [2][N];
    logic [7:0]   plan_ctx  [2][N];

    logic [7:0] iss_sel [4], iss_idx [4], iss_val [4], iss_meta [4];
    logic       iss_ism [4];
    int         n_issue;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic fill_plan(input int k);
        plan_bool[k] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
        for (int i = 0; i < N; i++) begin
            plan_res[k][i] = 8'($urandom);
            plan_ctx[k][i] = 8'($urandom);
        end
    endtask

    task automatic drive_cells(input int k);
        cell_bool = plan_bool[k];
        for (int i = 0; i < N; i++) begin
            cell_result[8*i +: 8]  = plan_res[k][i];
            cell_context[8*i +: 8] = plan_ctx[k][i];
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] idx, input logic [7:0] val,
                           input logic [7:0] meta, input logic ism, input int hold);
        logic        e_err, e_hit;
        logic [7:0]  e_cell, e_v, e_c;
        logic [3:0]  e_cnt;
        int          e_lat, e_iss, f, lat;
        logic        pending;
        e_err = 1'b0; e_hit = 1'b0; e_cell = '0; e_v = '0; e_c = '0; e_cnt = '0; f = -1;
        if (op > 4'd8) begin
            e_err = 1'b1; e_lat = 0; e_iss = 0;
        end else if (op != 4'd8) begin
            e_lat = 3; e_iss = 1; f = lowest(plan_bool[0]);
            e_cnt = 4'($countones(plan_bool[0]));
            if (f >= 0) begin
                e_hit = 1'b1; e_cell = 8'(f); e_v = plan_res[0][f]; e_c = plan_ctx[0][f];
            end
        end else begin
            f = lowest(plan_bool[0]);
            if (f < 0) begin
                e_err = 1'b1; e_lat = 3; e_iss = 1;
            end else begin
                e_lat = 6; e_iss = 2; e_cell = 8'(f);
                e_hit = |plan_bool[1];
                e_cnt = 4'($countones(plan_bool[1]));
                e_v = plan_res[1][f]; e_c = plan_ctx[1][f];
            end
        end

        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_op = op; cmd_index = idx; cmd_value = val; cmd_metadata = meta; cmd_is_meta = ism;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_issue = 0; pending = 1'b0; lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (pending) begin
                drive_cells((n_issue > 1) ? 1 : 0);
                pending = 1'b0;
            end
            if (cell_selector != 8'hFF) begin
                if (n_issue < 4) begin
                    iss_sel[n_issue] = cell_selector; iss_idx[n_issue] = cell_index;
                    iss_val[n_issue] = cell_value; iss_meta[n_issue] = cell_metadata;
                    iss_ism[n_issue] = cell_is_meta;
                end
                n_issue++;
                pending = 1'b1;
            end
            if (rsp_valid) lat = k - 1;
        end
        chk("latency", lat, e_lat);
        chk("issue_count", n_issue, e_iss);
        if (e_iss >= 1 && n_issue >= 1) begin
            chk("issue1_sel", iss_sel[0], (op == 4'd8) ? 8'd5 : {5'd0, op[2:0]});
            chk("issue1_ops", {iss_idx[0], iss_val[0], iss_meta[0], 7'd0, iss_ism[0]},
                {idx, val, meta, 7'd0, ism});
        end
        if (e_iss == 2 && n_issue >= 2) begin
            chk("issue2_sel", iss_sel[1], 8'd0);
            chk("issue2_ops", {iss_idx[1], iss_val[1], iss_meta[1], 7'd0, iss_ism[1]},
                {idx, val, 8'(f), 8'd1});
        end
        chk("rsp_flags", {rsp_err, rsp_hit}, {e_err, e_hit});
        chk("rsp_cell", rsp_cell, e_cell);
        chk("rsp_count", rsp_count, e_cnt);
        chk("rsp_data", {rsp_value, rsp_context}, {e_v, e_c});
        // a pending command during the stall must not be taken
        if (hold > 0) cmd_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("stall_hs", {rsp_valid, cmd_ready}, 2'b10);
            chk("stall_fields", {rsp_err, rsp_hit, rsp_cell, rsp_count, rsp_value, rsp_context},
                {e_err, e_hit, e_cell, e_cnt, e_v, e_c});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("handshake_done", {rsp_valid, cmd_ready, cell_selector}, {2'b01, 8'hFF});
    endtask

    initial begin
        for (int k = 0; k < 2; k++) fill_plan(k);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hs", {cmd_ready, rsp_valid}, 2'b10);
        chk("reset_sel", cell_selector, 8'hFF);
        chk("reset_rsp", {rsp_err, rsp_hit, rsp_cell, rsp_count, rsp_value, rsp_context}, 0);
        chk("reset_ops", {cell_index, cell_value, cell_metadata, 7'd0, cell_is_meta}, 0);
        @(negedge clk) rst_n = 1'b1;

        // reset while op 3 is on the bus
        @(negedge clk);
        cmd_op = 4'd3; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("mid_issue_sel", cell_selector, 8'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_state", {cell_selector, cmd_ready, rsp_valid}, {8'hFF, 2'b10});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_state", {cell_selector, cmd_ready, rsp_valid}, {8'hFF, 2'b10});

        // lookup hitting cells 2 and 5
        fill_plan(0);
        plan_bool[0] = 8'b0010_0100; plan_res[0][2] = 8'h5A; plan_ctx[0][2] = 8'h03;
        run_cmd(4'd1, 8'h11, 8'h22, 8'h00, 1'b0, 0);

        // allocate-and-insert with free cells {4,6}
        fill_plan(0); fill_plan(1);
        plan_bool[0] = 8'b0101_0000; plan_bool[1] = 8'b0001_0000;
        run_cmd(4'd8, 8'h07, 8'h33, 8'h9C, 1'b0, 0);

        // allocate-and-insert with no free cell
        fill_plan(0); plan_bool[0] = '0;
        run_cmd(4'd8, 8'h07, 8'h33, 8'h00, 1'b0, 0);

        // illegal opcode
        fill_plan(0);
        run_cmd(4'd12, 8'h01, 8'h02, 8'h03, 1'b1, 0);

        // response stalled for five cycles
        fill_plan(0); plan_bool[0] = 8'b1000_0000;
        run_cmd(4'd6, 8'hA5, 8'h5A, 8'h3C, 1'b1, 5);

        for (int t = 0; t < 40; t++) begin
            int r;
            logic [3:0] op;
            r = $urandom_range(0, 9);
            if (r < 5)      op = 4'($urandom_range(0, 7));
            else if (r < 8) op = 4'd8;
            else            op = 4'($urandom_range(9, 15));
            fill_plan(0); fill_plan(1);
            run_cmd(op, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
